snes_input_arbiter: RTL

Parametrised successor to the fixed 3-way controller-source mux plus SNES encoder path. Accepts CHANNELS independent button sources (keyboard, IR, button board, future sources), holds event-style inputs for a programmable time, selects or merges them by mode, and serialises the result to the SNES console on its latch/clock handshake. Sits between the per-source decoders and the console connector, in the system clock domain.

---
 rtl/snes_input_arbiter.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/snes_input_arbiter.sv
// snes_input_arbiter
// Collects CHANNELS button sources, holds event-style vectors, picks or merges
// them by mode, and shifts the chosen vector out on the SNES latch/clock
// handshake (bit 0 first, active-low on the wire).
// Build option: define INPUT_HOLD_EN to enable per-channel hold-time expiry.
module snes_input_arbiter #(
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 8,
    parameter int HOLD_TICKS = 1000,
    parameter int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic [CHANNELS-1:0]       ch_valid,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      snes_latch,
    input  logic                      snes_clk,
    output logic                      snes_out,
    output logic [SEL_W-1:0]          active_ch,
    output logic [WIDTH-1:0]          buttons
);

    // ------------------------------------------------------------------
    // Hold stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    held_q [CHANNELS];
    logic [WIDTH-1:0]    held_d [CHANNELS];
    logic [CHANNELS-1:0] nz_strobe;
    logic [CHANNELS-1:0] nz_strobe_q;

    // Flag strobes that carry at least one pressed button
    always_comb begin
        nz_strobe = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            nz_strobe[i] = ch_valid[i] && (ch_data[i*WIDTH +: WIDTH] != '0);
        end
    end

`ifdef INPUT_HOLD_EN
    localparam int CNT_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);

    logic [CNT_W-1:0] cnt_q [CHANNELS];
    logic [CNT_W-1:0] cnt_d [CHANNELS];

    // Capture on strobe, otherwise count down and clear on the 1->0 step
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            held_d[i] = held_q[i];
            cnt_d[i]  = cnt_q[i];
            if (ch_valid[i]) begin
                held_d[i] = ch_data[i*WIDTH +: WIDTH];
                cnt_d[i]  = nz_strobe[i] ? HOLD_LOAD : '0;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
                if (cnt_q[i] == CNT_W'(1)) begin
                    held_d[i] = '0;
                end
            end
        end
    end

    // Hold-time counters
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    // HOLD_TICKS has no effect without expiry counters
    logic unused_hold_ticks;
    assign unused_hold_ticks = (HOLD_TICKS != 0);

    // Held vectors change only on their own strobe
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            held_d[i] = ch_valid[i] ? ch_data[i*WIDTH +: WIDTH] : held_q[i];
        end
    end
`endif

    // Held vectors and the strobes that loaded them, kept in step
    always_ff @(posedge clk) begin
        if (reset) begin
            nz_strobe_q <= '0;
        end else begin
            nz_strobe_q <= nz_strobe;
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                held_q[i] <= '0;
            end else begin
                held_q[i] <= held_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Select stage
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] la_q;
    logic [SEL_W-1:0] la_d;
    logic [SEL_W-1:0] active_q;
    logic [SEL_W-1:0] active_d;
    logic [WIDTH-1:0] buttons_q;
    logic [WIDTH-1:0] buttons_d;
    logic [WIDTH-1:0] held_or;
    logic             held_any;
    logic [SEL_W-1:0] held_low;
    logic             strobe_any;
    logic [SEL_W-1:0] strobe_low;
    logic             sel_ok;

    // Summaries of the held vectors and of the strobes that just landed
    always_comb begin
        held_or    = '0;
        held_any   = 1'b0;
        held_low   = '0;
        strobe_any = 1'b0;
        strobe_low = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            held_or = held_or | held_q[i];
            if (!held_any && (held_q[i] != '0)) begin
                held_any = 1'b1;
                held_low = SEL_W'(i);
            end
            if (!strobe_any && nz_strobe_q[i]) begin
                strobe_any = 1'b1;
                strobe_low = SEL_W'(i);
            end
        end
    end

    // Last-active pointer runs in every mode so switching into last-active
    // mode picks up strobes that arrived while another mode was selected
    always_comb begin
        la_d = la_q;
        if (strobe_any) begin
            la_d = strobe_low;
        end else if ((held_q[la_q] == '0) && held_any) begin
            la_d = held_low;
        end
    end

    // Mode-dependent choice of the vector presented to the encoder
    always_comb begin
        sel_ok    = (int'(sel) < CHANNELS);
        buttons_d = '0;
        active_d  = active_q;
        case (mode)
            2'b01: begin
                buttons_d = held_q[la_d];
                active_d  = la_d;
            end
            2'b10: begin
                buttons_d = held_or;
                if (held_any) begin
                    active_d = held_low;
                end
            end
            default: begin
                if (sel_ok) begin
                    buttons_d = held_q[sel];
                    active_d  = sel;
                end
            end
        endcase
    end

    // Selected vector and channel registers
    always_ff @(posedge clk) begin
        if (reset) begin
            la_q      <= '0;
            active_q  <= '0;
            buttons_q <= '0;
        end else begin
            la_q      <= la_d;
            active_q  <= active_d;
            buttons_q <= buttons_d;
        end
    end

    assign buttons   = buttons_q;
    assign active_ch = active_q;

    // ------------------------------------------------------------------
    // Console handshake synchroniser
    // ------------------------------------------------------------------
    logic latch_s1_q;
    logic latch_s2_q;
    logic sclk_s1_q;
    logic sclk_s2_q;
    logic sclk_s3_q;
    logic sclk_rise;

    // Two-flop synchronisers plus one extra stage for clock edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_s1_q <= 1'b0;
            latch_s2_q <= 1'b0;
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_s3_q  <= 1'b0;
        end else begin
            latch_s1_q <= snes_latch;
            latch_s2_q <= latch_s1_q;
            sclk_s1_q  <= snes_clk;
            sclk_s2_q  <= sclk_s1_q;
            sclk_s3_q  <= sclk_s2_q;
        end
    end

    assign sclk_rise = sclk_s2_q && !sclk_s3_q;

    // ------------------------------------------------------------------
    // Serial encoder
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } enc_state_t;

    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);

    enc_state_t       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BC_W-1:0]  bitcnt_q;
    logic             out_q;

    // Encoder FSM; shreg holds the bits still to be sent after the one on
    // snes_out, so the output stays a plain register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            out_q    <= 1'b1;
        end else if (latch_s2_q) begin
            state_q  <= ST_LOAD;
            shreg_q  <= buttons_q >> 1;
            bitcnt_q <= '0;
            out_q    <= ~buttons_q[0];
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_q <= 1'b1;
                end
                ST_LOAD: begin
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        if (bitcnt_q == BC_LAST) begin
                            state_q <= ST_DONE;
                            out_q   <= 1'b1;
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                            shreg_q  <= shreg_q >> 1;
                            out_q    <= ~shreg_q[0];
                        end
                    end
                end
                ST_DONE: begin
                    out_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    out_q   <= 1'b1;
                end
            endcase
        end
    end

    assign snes_out = out_q;

endmodule
